// File: rtl/axo_pkg.sv
// Shared execute-stage definitions for the sequential divider: FSM states and
// RV32M divide funct3 encodings.
package axo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } axo_div_state_t;

    localparam logic [2:0] RV_MULDIV_DIV  = 3'b100;
    localparam logic [2:0] RV_MULDIV_DIVU = 3'b101;
    localparam logic [2:0] RV_MULDIV_REM  = 3'b110;
    localparam logic [2:0] RV_MULDIV_REMU = 3'b111;

    // funct3[2] is always set for divides; the low bits carry the whole meaning.
    localparam int F3_UNSIGNED_BIT = 0;
    localparam int F3_REM_BIT      = 1;

endpackage

// File: rtl/axo32_div_seq_if.sv
// Request/result handshake bundle between the execute stage and the divider.
interface axo32_div_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_lhs;
    logic [XLEN-1:0] req_rhs;
    logic            req_kill;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;

    modport master (
        output req_valid, req_funct3, req_lhs, req_rhs, req_kill, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_funct3, req_lhs, req_rhs, req_kill, res_ready,
        output req_ready, res_valid, res_data
    );
endinterface

// File: rtl/axo32_div_step.sv
// One radix-2 restoring division step, purely combinational.
// The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
module axo32_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          borrow;

    assign shifted = {rem, quot[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};
    // rem < divisor holds between steps, so a non-borrowing diff always fits in XLEN bits.
    assign borrow  = diff[XLEN];

    assign rem_next  = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_next = {quot[XLEN-2:0], ~borrow};

endmodule

// File: rtl/axo32_div_seq.sv
// Sequential RV32M DIV/DIVU/REM/REMU unit; result valid XLEN+1 cycles after accept
// (1 cycle for trivial operands when AXO_DIV_FAST_EN is defined). req_ready only in IDLE;
// result held in DONE until res_ready; req_kill aborts from any state.
module axo32_div_seq
    import axo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    axo32_div_seq_if.slave     bus
);

    localparam int            CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    axo_div_state_t  state;
    logic [CW-1:0]   cnt;
    logic            unsigned_op;
    logic            rem_op;
    logic            sign_lhs;
    logic            sign_rhs;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic            res_valid_r;
    logic [XLEN-1:0] res_data_r;

    logic            lhs_neg;
    logic            rhs_neg;
    logic [XLEN-1:0] lhs_mag;
    logic [XLEN-1:0] rhs_mag;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_step;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic            unused_f3_msb;

    assign unused_f3_msb = bus.req_funct3[2];

    assign lhs_neg = ~bus.req_funct3[F3_UNSIGNED_BIT] & bus.req_lhs[XLEN-1];
    assign rhs_neg = ~bus.req_funct3[F3_UNSIGNED_BIT] & bus.req_rhs[XLEN-1];
    assign lhs_mag = lhs_neg ? -bus.req_lhs : bus.req_lhs;
    assign rhs_mag = rhs_neg ? -bus.req_rhs : bus.req_rhs;

    axo32_div_step #(.XLEN(XLEN)) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    // Divide-by-zero keeps the all-ones quotient unsigned, matching the RISC-V result.
    assign quot_fix = (~unsigned_op & (sign_lhs ^ sign_rhs) & (divisor != '0)) ? -quot : quot;
    assign rem_fix  = (~unsigned_op & sign_lhs) ? -rem : rem;

`ifdef AXO_DIV_FAST_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            fast_hit;
    logic [XLEN-1:0] fast_quot;
    logic [XLEN-1:0] fast_rem;

    // Fast results are stored as magnitudes so the common sign fix-up applies unchanged.
    always_comb begin
        fast_hit  = 1'b1;
        fast_quot = '0;
        fast_rem  = lhs_mag;
        if (rhs_mag == '0) begin
            fast_quot = '1;
        end else if (~bus.req_funct3[F3_UNSIGNED_BIT] && bus.req_lhs == INT_MIN
                     && bus.req_rhs == '1) begin
            fast_quot = INT_MIN;
            fast_rem  = '0;
        end else if (lhs_mag >= rhs_mag) begin
            fast_hit  = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else if (bus.req_kill) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        unsigned_op <= bus.req_funct3[F3_UNSIGNED_BIT];
                        rem_op      <= bus.req_funct3[F3_REM_BIT];
                        sign_lhs    <= lhs_neg;
                        sign_rhs    <= rhs_neg;
                        divisor     <= rhs_mag;
                        quot        <= lhs_mag;
                        rem         <= '0;
                        cnt         <= CNT_INIT;
                        state       <= CALC;
`ifdef AXO_DIV_FAST_EN
                        if (fast_hit) begin
                            quot  <= fast_quot;
                            rem   <= fast_rem;
                            cnt   <= '0;
                            state <= DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    rem  <= rem_step;
                    quot <= quot_step;
                    cnt  <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the fixed-up result; then wait for the consumer.
                    if (!res_valid_r) begin
                        res_valid_r <= 1'b1;
                        res_data_r  <= rem_op ? rem_fix : quot_fix;
                    end else if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;

endmodule
